ps2_rx: RTL

- PS/2 device-to-host frame receiver. Sits directly upstream of the keyboard scan-code decoder and feeds it one byte per frame.
- Synchronises and de-glitches the raw ps2_clk and ps2_data pins, then deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Delivers each byte with a one-cycle valid strobe.
- Receive-only; host-to-device transmission (LED commands) belongs to a separate block.

---
 rtl/ps2_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisation, glitch filtering,
// 11-bit frame deserialisation with odd-parity and stop-bit checking, and an
// inter-edge timeout that abandons stalled partial frames.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       idle
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic              clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic              clk_f_q, clk_f_d, data_f_q, data_f_d;
    logic [FCNT_W-1:0] clk_fcnt_q, clk_fcnt_d, data_fcnt_q, data_fcnt_d;
    logic              fall_q, fall_d;

    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        data_out_q;
    logic              data_valid_q, frame_err_q, idle_q;

    // Two-flop synchronisers; lines idle high so they reset to 1
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Glitch filters: flip only after FILTER_LEN consecutive differing samples
    always_comb begin
        clk_f_d     = clk_f_q;
        clk_fcnt_d  = '0;
        data_f_d    = data_f_q;
        data_fcnt_d = '0;
        if (clk_s2_q != clk_f_q) begin
            if (clk_fcnt_q == FCNT_W'(FILTER_LEN - 1)) clk_f_d = clk_s2_q;
            else clk_fcnt_d = clk_fcnt_q + FCNT_W'(1);
        end
        if (data_s2_q != data_f_q) begin
            if (data_fcnt_q == FCNT_W'(FILTER_LEN - 1)) data_f_d = data_s2_q;
            else data_fcnt_d = data_fcnt_q + FCNT_W'(1);
        end
        fall_d = clk_f_q & ~clk_f_d;
    end

    // Filter state and registered falling-edge event
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f_q     <= 1'b1;
            data_f_q    <= 1'b1;
            clk_fcnt_q  <= '0;
            data_fcnt_q <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_f_q     <= clk_f_d;
            data_f_q    <= data_f_d;
            clk_fcnt_q  <= clk_fcnt_d;
            data_fcnt_q <= data_fcnt_d;
            fall_q      <= fall_d;
        end
    end

    // Frame FSM with timeout; an edge event always takes priority over timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            idle_q       <= (state_q == S_IDLE) && clk_f_q;
            if (fall_q) begin
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (!data_f_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= {data_f_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                        else bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: begin
                        parity_q <= data_f_q;
                        state_q  <= S_STOP;
                    end
                    default: begin
                        if (data_f_q && (^{shift_q, parity_q})) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q   <= S_IDLE;
                        bit_cnt_q <= '0;
                    end
                endcase
            end else if (state_q == S_IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
                bit_cnt_q   <= '0;
                tmo_q       <= '0;
            end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign idle       = idle_q;

endmodule
